// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - carry-chunked pipelined adder/subtractor with valid/ready flow control
// Each rank adds one CHUNK of the operands; unused operand bits and finished sum bits ride along.
module pipe_adder #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int CHUNK = WIDTH / ((STAGES < 1) ? 1 : STAGES);

   if (STAGES < 1 || STAGES > WIDTH || (WIDTH % ((STAGES < 1) ? 1 : STAGES)) != 0) begin : g_param_check
      $error("pipe_adder: STAGES must be in 1..WIDTH and divide WIDTH");
   end

   logic             en;
   logic [WIDTH-1:0] s_q;
   logic             cout_q;
   logic             ovf_q;
   logic             zero_q;
   logic             vld_q;

   assign en        = !out_valid || out_ready;
   assign in_ready  = en;
   assign s         = s_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;
   assign out_valid = vld_q;

   for (genvar k = 0; k < STAGES; k++) begin : g_rank
      // Rank k sees only the operand bits not yet consumed and the sum bits already produced.
      localparam int HW = WIDTH - k * CHUNK;
      localparam int LW = k * CHUNK;

      logic [HW-1:0]       a_i;
      logic [HW-1:0]       b_i;
      logic                c_i;
      logic                v_i;
      logic [CHUNK:0]      sum;
      logic [LW+CHUNK-1:0] s_nx;

      assign sum = {1'b0, a_i[CHUNK-1:0]} + {1'b0, b_i[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_i};

      if (k == 0) begin : g_src
         assign a_i  = a;
         assign b_i  = sub ? ~b : b;
         assign c_i  = cin ^ sub;
         assign v_i  = in_valid;
         assign s_nx = sum[CHUNK-1:0];
      end else begin : g_chain
         assign a_i  = g_rank[k-1].g_fwd.a_r;
         assign b_i  = g_rank[k-1].g_fwd.b_r;
         assign c_i  = g_rank[k-1].g_fwd.c_r;
         assign v_i  = g_rank[k-1].g_fwd.v_r;
         assign s_nx = {sum[CHUNK-1:0], g_rank[k-1].g_fwd.s_r};
      end

      if (k < STAGES - 1) begin : g_fwd
         logic [HW-CHUNK-1:0] a_r;
         logic [HW-CHUNK-1:0] b_r;
         logic [LW+CHUNK-1:0] s_r;
         logic                c_r;
         logic                v_r;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_r <= '0;
               b_r <= '0;
               s_r <= '0;
               c_r <= 1'b0;
               v_r <= 1'b0;
            end else if (en) begin
               a_r <= a_i[HW-1:CHUNK];
               b_r <= b_i[HW-1:CHUNK];
               s_r <= s_nx;
               c_r <= sum[CHUNK];
               v_r <= v_i;
            end
         end
      end else begin : g_out
         // Final rank holds the top chunk, whose MSBs decide signed overflow.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s_q    <= '0;
               cout_q <= 1'b0;
               ovf_q  <= 1'b0;
               zero_q <= 1'b0;
               vld_q  <= 1'b0;
            end else if (en) begin
               s_q    <= s_nx;
               cout_q <= sum[CHUNK];
               ovf_q  <= (a_i[HW-1] == b_i[HW-1]) && (s_nx[WIDTH-1] != a_i[HW-1]);
               zero_q <= (s_nx == '0);
               vld_q  <= v_i;
            end
         end
      end
   end

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - scoreboard bench for pipe_adder (WIDTH=8, STAGES=2)
module tb_pipe_adder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] a, b, s;
   logic       cin, sub, in_valid, in_ready, cout, ovf, zero, out_valid, out_ready;

   typedef struct packed {
      logic [7:0] s;
      logic       c;
      logic       o;
      logic       z;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   total = 0;
   int   bad   = 0;
   int   idx;
   logic go;
   logic [7:0] va[4] = '{8'h11, 8'h80, 8'hF0, 8'h7F};
   logic [7:0] vb[4] = '{8'h22, 8'h80, 8'h20, 8'h7F};

   pipe_adder #(.WIDTH(8), .STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .sub(sub),
      .in_valid(in_valid), .in_ready(in_ready), .s(s), .cout(cout),
      .ovf(ovf), .zero(zero), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input logic ts);
      exp_t m;
      int   r, sr;
      if (!ts) begin
         r   = int'(ta) + int'(tb) + int'(tc);
         sr  = int'($signed(ta)) + int'($signed(tb)) + int'(tc);
         m.c = (r > 255);
      end else begin
         r   = int'(ta) - int'(tb) - int'(tc);
         sr  = int'($signed(ta)) - int'($signed(tb)) - int'(tc);
         m.c = (r >= 0);
      end
      m.s = r[7:0];
      m.o = (sr > 127) || (sr < -128);
      m.z = (m.s == 8'h00);
      return m;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("spurious_out", out_valid, 0);
            end else begin
               e = q[0];
               chk("s", s, e.s);
               chk("cout", cout, e.c);
               chk("ovf", ovf, e.o);
               chk("zero", zero, e.z);
               if (out_ready) void'(q.pop_front());
            end
         end
         if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input logic ts);
      int n;
      n = 0;
      a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (q.size() != 0 && n < 50) begin
         step();
         n++;
      end
      chk("drain_empty", q.size(), 0);
      step();
   endtask

   initial begin
      rst_n = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #3;
      chk("rst_s", s, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_zero", zero, 0);
      chk("rst_ov", out_valid, 0);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      step();

      // first transaction from an empty pipe: valid after the second edge
      send(8'h0F, 8'h01, 1'b0, 1'b0);
      @(negedge clk);
      chk("lat_early", out_valid, 0);
      @(negedge clk);
      chk("lat_due", out_valid, 1);
      chk("r37_s", s, 8'h10);
      step();

      send(8'hFF, 8'h01, 1'b0, 1'b0);
      send(8'h7F, 8'h01, 1'b0, 1'b0);
      send(8'h05, 8'h07, 1'b0, 1'b1);
      send(8'h07, 8'h05, 1'b1, 1'b1);
      send(8'h80, 8'h7F, 1'b1, 1'b1);
      send(8'h00, 8'h80, 1'b0, 1'b1);
      drain();

      // stall: only two fit while out_ready is low
      out_ready = 1'b0;
      idx = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         a = va[idx]; b = vb[idx]; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
         @(negedge clk);
         go = in_ready;
         step();
         if (go) idx++;
      end
      chk("stall_count", idx, 2);
      chk("stall_in_ready", in_ready, 0);
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 20 && idx < 4; cyc++) begin
         a = va[idx]; b = vb[idx]; in_valid = 1'b1;
         @(negedge clk);
         go = in_ready;
         step();
         if (go) idx++;
      end
      chk("stall_all_sent", idx, 4);
      drain();

      // alternating bubbles
      for (int i = 0; i < 10; i++) begin
         a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
         in_valid = (i % 2 == 0);
         @(negedge clk);
         chk("alt_out_valid", out_valid, (i >= 2 && i % 2 == 0));
         step();
      end
      drain();

      // async reset with two transactions in flight
      send(8'h12, 8'h34, 1'b0, 1'b0);
      send(8'h56, 8'h78, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_s", s, 0);
      chk("midrst_cout", cout, 0);
      chk("midrst_ovf", ovf, 0);
      chk("midrst_zero", zero, 0);
      chk("midrst_ov", out_valid, 0);
      q.delete();
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("postrst_ov", out_valid, 0);
         step();
      end
      send(8'hA5, 8'h5A, 1'b1, 1'b0);
      drain();

      // random traffic with random backpressure
      for (int i = 0; i < 300; i++) begin
         a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
         in_valid  = 1'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
